axi4lite_manager: RTL and testbench

Single-outstanding AXI4-Lite manager (initiator) that turns a simple valid/ready command stream into one AXI4-Lite read or write transaction at a time and returns the result on a response stream. It drives the initiator side of the team's AXI4-Lite register ports, such as the `t_ctrl` / `t_sideband` / `t_mem` subordinate ports on PIO-class peripherals. It is used by test sequencers, boot ROM walkers and bridge logic.

---
 rtl/axi4lite_manager.sv | 193 +++++++++++++++++++
 tb/tb_axi4lite_manager.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_manager.sv
// Single-outstanding AXI4-Lite manager: converts a valid/ready command stream into
// one AXI4-Lite read or write at a time and returns the result on a response stream.
`timescale 1ns/1ps
module axi4lite_manager #(
  parameter int unsigned addrWidth        = 32,
  parameter int unsigned dataWidth        = 32,
  parameter int unsigned writeStrobeWidth = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [addrWidth-1:0]        cmd_addr,
  input  logic [dataWidth-1:0]        cmd_wdata,
  input  logic [writeStrobeWidth-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [dataWidth-1:0]        rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        busy,
  output logic                        i_awvalid,
  input  logic                        i_awready,
  output logic [addrWidth-1:0]        i_awaddr,
  output logic [2:0]                  i_awprot,
  output logic                        i_wvalid,
  input  logic                        i_wready,
  output logic [dataWidth-1:0]        i_wdata,
  output logic [writeStrobeWidth-1:0] i_wstrb,
  input  logic                        i_bvalid,
  output logic                        i_bready,
  input  logic [1:0]                  i_bresp,
  output logic                        i_arvalid,
  input  logic                        i_arready,
  output logic [addrWidth-1:0]        i_araddr,
  output logic [2:0]                  i_arprot,
  input  logic                        i_rvalid,
  output logic                        i_rready,
  input  logic [dataWidth-1:0]        i_rdata,
  input  logic [1:0]                  i_rresp
);

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_WR   = 6'b000010;
  localparam logic [5:0] S_WB   = 6'b000100;
  localparam logic [5:0] S_RA   = 6'b001000;
  localparam logic [5:0] S_RR   = 6'b010000;
  localparam logic [5:0] S_RSP  = 6'b100000;

  logic [5:0]                  state_q, state_d;
  logic [addrWidth-1:0]        addr_q, addr_d;
  logic [dataWidth-1:0]        wdata_q, wdata_d;
  logic [writeStrobeWidth-1:0] wstrb_q, wstrb_d;
  logic                        write_q, write_d;
  logic [dataWidth-1:0]        rdata_q, rdata_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        aw_hs, w_hs;

  assign aw_hs = aw_valid_q & i_awready;
  assign w_hs  = w_valid_q & i_wready;

  // State and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= 2'b00;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          if (cmd_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = S_WR;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = S_RA;
          end
        end
      end
      S_WR: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = S_WB;
      end
      S_WB: begin
        if (i_bvalid) begin
          resp_d  = i_bresp;
          rdata_d = '0;
          write_d = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RA: begin
        if (i_arready) begin
          ar_valid_d = 1'b0;
          state_d    = S_RR;
        end
      end
      S_RR: begin
        if (i_rvalid) begin
          rdata_d = i_rdata;
          resp_d  = i_rresp;
          write_d = 1'b0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Readies and status are decoded from the one-hot state register
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign i_bready  = (state_q == S_WB);
  assign i_rready  = (state_q == S_RR);

  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign i_awvalid = aw_valid_q;
  assign i_awaddr  = addr_q;
  assign i_awprot  = 3'b000;
  assign i_wvalid  = w_valid_q;
  assign i_wdata   = wdata_q;
  assign i_wstrb   = wstrb_q;
  assign i_arvalid = ar_valid_q;
  assign i_araddr  = addr_q;
  assign i_arprot  = 3'b000;

endmodule

// File: tb/tb_axi4lite_manager.sv
// Scoreboard bench for axi4lite_manager with a configurable AXI4-Lite subordinate model.
`timescale 1ns/1ps
module tb_axi4lite_manager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        i_awvalid, i_awready, i_wvalid, i_wready, i_bvalid, i_bready;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic [31:0] i_awaddr, i_wdata, i_araddr, i_rdata;
  logic [3:0]  i_wstrb;
  logic [2:0]  i_awprot, i_arprot;
  logic [1:0]  i_bresp, i_rresp;

  axi4lite_manager #(.addrWidth(32), .dataWidth(32), .writeStrobeWidth(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awaddr(i_awaddr), .i_awprot(i_awprot),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bresp(i_bresp),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arprot(i_arprot),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Subordinate model: programmable AW/W ready delays, B/R one cycle after the handshakes
  int          aw_delay = 0, w_delay = 0;
  logic        hold_b = 1'b0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = '0;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got, aw_pend, w_pend;
  logic        aw_hs, w_hs;

  assign i_awready = i_awvalid && (aw_cnt >= aw_delay);
  assign i_wready  = i_wvalid && (w_cnt >= w_delay);
  assign i_arready = i_arvalid;
  assign aw_hs     = i_awvalid && i_awready;
  assign w_hs      = i_wvalid && i_wready;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_pend <= 1'b0; w_pend <= 1'b0;
      i_bvalid <= 1'b0; i_bresp <= 2'b00;
      i_rvalid <= 1'b0; i_rdata <= '0; i_rresp <= 2'b00;
    end else begin
      aw_cnt  <= (i_awvalid && !i_awready) ? aw_cnt + 1 : 0;
      w_cnt   <= (i_wvalid && !i_wready) ? w_cnt + 1 : 0;
      aw_pend <= i_awvalid && !i_awready;
      w_pend  <= i_wvalid && !i_wready;
      if (i_bvalid && i_bready) i_bvalid <= 1'b0;
      if (!hold_b && (aw_got || aw_hs) && (w_got || w_hs)) begin
        i_bvalid <= 1'b1;
        i_bresp  <= b_resp;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (i_arvalid && i_arready) begin
        i_rvalid <= 1'b1;
        i_rdata  <= r_data;
        i_rresp  <= r_resp;
      end else if (i_rvalid && i_rready) begin
        i_rvalid <= 1'b0;
      end
    end
  end

  // Held valids must stay high with the captured payload; B only after AW and W are done
  always @(negedge clk) begin
    if (reset_n) begin
      if (aw_pend) begin
        check("aw_valid_held", 64'(i_awvalid), 64'd1);
        check("aw_addr_stable", 64'(i_awaddr), 64'(exp_addr));
      end
      if (w_pend) begin
        check("w_valid_held", 64'(i_wvalid), 64'd1);
        check("w_data_stable", 64'({i_wdata, i_wstrb}), 64'({exp_wdata, exp_wstrb}));
      end
      if (i_bready) check("bready_after_aw_w", 64'({i_awvalid, i_wvalid}), 64'd0);
    end
  end

  // Response monitor: pop the expectation on every response handshake
  always @(negedge clk) begin : rsp_mon
    exp_t e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_write", 64'(rsp_write), 64'(e.write));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        if (e.cyc >= 0) check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Present a command, wait for acceptance, push its expected response (lat<0: no timing check)
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] erdata, input logic [1:0] eresp,
                       input int lat, input bit push, output int n);
    exp_t e;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
    exp_addr = addr; exp_wdata = wdata; exp_wstrb = strb;
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) begin
      check("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.write = wr;
      e.rdata = wr ? 32'h0 : erdata;
      e.resp  = eresp;
      e.cyc   = (lat >= 0) ? n + lat : -1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, h;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy_rsp_valid", 64'({busy, rsp_valid}), 64'd0);
    check("rst_axi_valids", 64'({i_awvalid, i_wvalid, i_arvalid}), 64'd0);
    check("rst_axi_readies", 64'({i_bready, i_rready}), 64'd0);
    check("rst_rsp_payload", 64'({rsp_rdata, rsp_resp, rsp_write}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write
    issue(1'b1, 32'h0, 32'h1234, 4'hF, 32'h0, 2'b00, 3, 1'b1, n);
    @(negedge clk);
    check("wr_aw_w_valid_n1", 64'({i_awvalid, i_wvalid}), 64'h3);
    check("wr_awaddr", 64'(i_awaddr), 64'h0);
    check("wr_wdata_wstrb", 64'({i_wdata, i_wstrb}), 64'({32'h1234, 4'hF}));
    check("wr_prot", 64'({i_awprot, i_arprot}), 64'd0);
    drain();

    // Zero-wait read
    r_data = 32'h3FF;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'h3FF, 2'b00, 3, 1'b1, n);
    @(negedge clk);
    check("rd_arvalid_n1", 64'(i_arvalid), 64'd1);
    check("rd_araddr", 64'(i_araddr), 64'h8);
    drain();

    // W ready late, then AW ready late
    w_delay = 3;
    issue(1'b1, 32'h10, 32'hA5A5_5A5A, 4'h3, 32'h0, 2'b00, 6, 1'b1, n);
    drain();
    w_delay = 0; aw_delay = 3;
    issue(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hC, 32'h0, 2'b00, 6, 1'b1, n);
    drain();
    aw_delay = 0;

    // Error responses pass through, then a normal read
    r_resp = 2'b10; r_data = 32'h55;
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h55, 2'b10, 3, 1'b1, n);
    drain();
    r_resp = 2'b00; b_resp = 2'b11;
    issue(1'b1, 32'h24, 32'h0BAD, 4'hF, 32'h0, 2'b11, 3, 1'b1, n);
    drain();
    b_resp = 2'b00; r_data = 32'h77;
    issue(1'b0, 32'h28, 32'h0, 4'h0, 32'h77, 2'b00, 3, 1'b1, n);
    drain();

    // Response back-pressure with the next command waiting
    rsp_ready = 1'b0; r_data = 32'h1CE;
    issue(1'b0, 32'h30, 32'h0, 4'h0, 32'h1CE, 2'b00, -1, 1'b1, n);
    cmd_write = 1'b1; cmd_addr = 32'h34; cmd_wdata = 32'h99; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_payload", 64'({rsp_rdata, rsp_resp, rsp_write}), 64'({32'h1CE, 2'b00, 1'b0}));
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    h = cyc;
    issue(1'b1, 32'h34, 32'h99, 4'hF, 32'h0, 2'b00, 3, 1'b1, n);
    check("bp_next_accept_cycle", 64'(n), 64'(h + 1));
    drain();

    // Asynchronous reset while waiting for B
    hold_b = 1'b1;
    issue(1'b1, 32'h40, 32'h1, 4'hF, 32'h0, 2'b00, -1, 1'b0, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i_bready) break;
    end
    check("rst_mid_reached_wb", 64'(i_bready), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_bready_busy_rspv", 64'({i_bready, busy, rsp_valid}), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_axi_valids", 64'({i_awvalid, i_wvalid, i_arvalid}), 64'd0);
    @(posedge clk); #1;
    hold_b = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    r_data = 32'h3C3;
    issue(1'b0, 32'h44, 32'h0, 4'h0, 32'h3C3, 2'b00, 3, 1'b1, n);
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
